// File: rtl/fpu_mem_arbiter.sv
// Round-robin arbiter merging the CPU and SRFPU memory ports onto one memory port, one transaction in flight.
// Optional BUSY watchdog enabled by defining MEM_TIMEOUT_EN.
module fpu_mem_arbiter #(
    parameter int addr_width     = 32,
    parameter int data_width     = 32,
    parameter int timeout_cycles = 256
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      cpu_mem_valid,
    output logic                      cpu_mem_ready,
    input  logic [addr_width-1:0]     cpu_mem_addr,
    input  logic [data_width-1:0]     cpu_mem_wdata,
    input  logic [data_width/8-1:0]   cpu_mem_wstrb,
    output logic [data_width-1:0]     cpu_mem_rdata,
    input  logic                      fpu_mem_valid,
    output logic                      fpu_mem_ready,
    input  logic [addr_width-1:0]     fpu_mem_addr,
    input  logic [data_width-1:0]     fpu_mem_wdata,
    input  logic [data_width/8-1:0]   fpu_mem_wstrb,
    output logic [data_width-1:0]     fpu_mem_rdata,
    output logic                      mem_valid,
    input  logic                      mem_ready,
    output logic [addr_width-1:0]     mem_addr,
    output logic [data_width-1:0]     mem_wdata,
    output logic [data_width/8-1:0]   mem_wstrb,
    input  logic [data_width-1:0]     mem_rdata,
    output logic [1:0]                grant_test,
    output logic                      timeout_err
);

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        BUSY_CPU = 2'b01,
        BUSY_FPU = 2'b10
    } state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic                  r_lastFpu;
    logic                  w_nextLastFpu;
    logic                  w_timeout;
    logic                  w_selValid;
    logic [data_width-1:0] w_rdata;

    assign w_selValid = (r_state == BUSY_CPU) ? cpu_mem_valid :
                        (r_state == BUSY_FPU) ? fpu_mem_valid : 1'b0;

`ifdef MEM_TIMEOUT_EN
    localparam int CntW = $clog2(timeout_cycles) + 1;

    function automatic logic [data_width-1:0] poisonWord();
        logic [31:0]           pat;
        logic [data_width-1:0] word;
        pat  = 32'hDEADBEEF;
        word = '0;
        for (int i = 0; i < data_width; i++) begin
            word[i] = pat[i % 32];
        end
        return word;
    endfunction

    localparam logic [data_width-1:0] Poison = poisonWord();

    logic [CntW-1:0] r_count;
    logic            r_timeoutErr;

    // Count stays cleared while IDLE, so every BUSY period starts from zero.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_count      <= '0;
            r_timeoutErr <= 1'b0;
        end else begin
            if (r_state == IDLE) begin
                r_count <= '0;
            end else if (!mem_ready) begin
                r_count <= r_count + 1'b1;
            end
            if (w_timeout) begin
                r_timeoutErr <= 1'b1;
            end
        end
    end

    assign w_timeout   = w_selValid && !mem_ready && (r_count == CntW'(timeout_cycles - 1));
    assign w_rdata     = w_timeout ? Poison : mem_rdata;
    assign timeout_err = r_timeoutErr;
`else
    assign w_timeout   = 1'b0;
    assign w_rdata     = mem_rdata;
    assign timeout_err = 1'b0;
`endif

    assign cpu_mem_rdata = w_rdata;
    assign fpu_mem_rdata = w_rdata;
    assign grant_test    = r_state;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= IDLE;
            r_lastFpu <= 1'b1;
        end else begin
            r_state   <= w_nextState;
            r_lastFpu <= w_nextLastFpu;
        end
    end

    always_comb begin
        w_nextState   = r_state;
        w_nextLastFpu = r_lastFpu;
        mem_valid     = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        mem_wstrb     = '0;
        cpu_mem_ready = 1'b0;
        fpu_mem_ready = 1'b0;
        case (r_state)
            IDLE: begin
                if (cpu_mem_valid && (!fpu_mem_valid || r_lastFpu)) begin
                    w_nextState = BUSY_CPU;
                end else if (fpu_mem_valid) begin
                    w_nextState = BUSY_FPU;
                end
            end
            BUSY_CPU: begin
                mem_valid     = cpu_mem_valid && !w_timeout;
                mem_addr      = cpu_mem_addr;
                mem_wdata     = cpu_mem_wdata;
                mem_wstrb     = cpu_mem_wstrb;
                cpu_mem_ready = cpu_mem_valid && (mem_ready || w_timeout);
                // A dropped request abandons the slot without updating fairness history.
                if (!cpu_mem_valid) begin
                    w_nextState = IDLE;
                end else if (mem_ready || w_timeout) begin
                    w_nextState   = IDLE;
                    w_nextLastFpu = 1'b0;
                end
            end
            BUSY_FPU: begin
                mem_valid     = fpu_mem_valid && !w_timeout;
                mem_addr      = fpu_mem_addr;
                mem_wdata     = fpu_mem_wdata;
                mem_wstrb     = fpu_mem_wstrb;
                fpu_mem_ready = fpu_mem_valid && (mem_ready || w_timeout);
                if (!fpu_mem_valid) begin
                    w_nextState = IDLE;
                end else if (mem_ready || w_timeout) begin
                    w_nextState   = IDLE;
                    w_nextLastFpu = 1'b1;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fpu_mem_arbiter.sv
// Self-checking bench for fpu_mem_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level round-robin model.
module tb_fpu_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          cpu_mem_valid = 1'b0;
    logic          cpu_mem_ready;
    logic [AW-1:0] cpu_mem_addr = '0;
    logic [DW-1:0] cpu_mem_wdata = '0;
    logic [SW-1:0] cpu_mem_wstrb = '0;
    logic [DW-1:0] cpu_mem_rdata;
    logic          fpu_mem_valid = 1'b0;
    logic          fpu_mem_ready;
    logic [AW-1:0] fpu_mem_addr = '0;
    logic [DW-1:0] fpu_mem_wdata = '0;
    logic [SW-1:0] fpu_mem_wstrb = '0;
    logic [DW-1:0] fpu_mem_rdata;
    logic          mem_valid;
    logic          mem_ready = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [SW-1:0] mem_wstrb;
    logic [DW-1:0] mem_rdata = '0;
    logic [1:0]    grant_test;
    logic          timeout_err;

    int   testCount = 0;
    int   failCount = 0;
    logic modelLastFpu = 1'b1;

    always #5 clk = ~clk;

    fpu_mem_arbiter #(
        .addr_width(AW),
        .data_width(DW),
        .timeout_cycles(8)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .cpu_mem_valid(cpu_mem_valid),
        .cpu_mem_ready(cpu_mem_ready),
        .cpu_mem_addr(cpu_mem_addr),
        .cpu_mem_wdata(cpu_mem_wdata),
        .cpu_mem_wstrb(cpu_mem_wstrb),
        .cpu_mem_rdata(cpu_mem_rdata),
        .fpu_mem_valid(fpu_mem_valid),
        .fpu_mem_ready(fpu_mem_ready),
        .fpu_mem_addr(fpu_mem_addr),
        .fpu_mem_wdata(fpu_mem_wdata),
        .fpu_mem_wstrb(fpu_mem_wstrb),
        .fpu_mem_rdata(fpu_mem_rdata),
        .mem_valid(mem_valid),
        .mem_ready(mem_ready),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata),
        .grant_test(grant_test),
        .timeout_err(timeout_err)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic isFpu, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] wdata, input logic [SW-1:0] wstrb);
        if (isFpu) begin
            fpu_mem_valid = 1'b1;
            fpu_mem_addr  = addr;
            fpu_mem_wdata = wdata;
            fpu_mem_wstrb = wstrb;
        end else begin
            cpu_mem_valid = 1'b1;
            cpu_mem_addr  = addr;
            cpu_mem_wdata = wdata;
            cpu_mem_wstrb = wstrb;
        end
    endtask

    // Serves one transaction starting from IDLE; the winner comes from the round-robin rule.
    task automatic serveTransaction(input int latency, input logic [DW-1:0] rdata, output logic [1:0] seenGrant);
        logic          winFpu;
        logic [AW-1:0] expAddr;
        logic [DW-1:0] expWdata;
        logic [SW-1:0] expWstrb;
        if (cpu_mem_valid && fpu_mem_valid) winFpu = !modelLastFpu;
        else                                winFpu = fpu_mem_valid;
        expAddr  = winFpu ? fpu_mem_addr  : cpu_mem_addr;
        expWdata = winFpu ? fpu_mem_wdata : cpu_mem_wdata;
        expWstrb = winFpu ? fpu_mem_wstrb : cpu_mem_wstrb;
        @(posedge clk);
        @(negedge clk);
        seenGrant = grant_test;
        checkOutput("grant", {62'd0, grant_test}, winFpu ? 64'd2 : 64'd1);
        checkOutput("busy_valid", {63'd0, mem_valid}, 64'd1);
        checkOutput("busy_addr", {32'd0, mem_addr}, {32'd0, expAddr});
        checkOutput("busy_wdata", {32'd0, mem_wdata}, {32'd0, expWdata});
        checkOutput("busy_wstrb", {60'd0, mem_wstrb}, {60'd0, expWstrb});
        checkOutput("busy_no_ready", {62'd0, cpu_mem_ready, fpu_mem_ready}, 64'd0);
        repeat (latency) @(negedge clk);
        mem_ready = 1'b1;
        mem_rdata = rdata;
        #1;
        checkOutput("ready_pulse", {62'd0, cpu_mem_ready, fpu_mem_ready}, winFpu ? 64'd1 : 64'd2);
        checkOutput("rdata", {32'd0, winFpu ? fpu_mem_rdata : cpu_mem_rdata}, {32'd0, rdata});
        @(posedge clk);
        @(negedge clk);
        mem_ready = 1'b0;
        if (winFpu) fpu_mem_valid = 1'b0;
        else        cpu_mem_valid = 1'b0;
        #1;
        checkOutput("idle_grant", {62'd0, grant_test}, 64'd0);
        checkOutput("idle_outputs", {31'd0, mem_valid, mem_addr}, 64'd0);
        modelLastFpu = winFpu;
    endtask

    initial begin
        logic [1:0] seen;
        $display("[TB] start");
        #2;
        checkOutput("reset_grant", {62'd0, grant_test}, 64'd0);
        checkOutput("reset_outputs", {29'd0, mem_valid, cpu_mem_ready, fpu_mem_ready, timeout_err, mem_addr}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Single CPU read
        applyStimulus(1'b0, 32'h100, 32'h0, 4'h0);
        serveTransaction(1, 32'h12345678, seen);

        // Simultaneous requests right after reset: CPU first, then FPU
        @(negedge clk);
        resetn = 1'b0;
        modelLastFpu = 1'b1;
        @(negedge clk);
        resetn = 1'b1;
        applyStimulus(1'b0, 32'h10, 32'h0, 4'h0);
        applyStimulus(1'b1, 32'h20, 32'h0, 4'h0);
        serveTransaction(0, 32'hA1, seen);
        checkOutput("simul_first", {62'd0, seen}, 64'd1);
        serveTransaction(0, 32'hA2, seen);
        checkOutput("simul_second", {62'd0, seen}, 64'd2);

        // Continuous contention alternates masters
        applyStimulus(1'b0, 32'h30, 32'h0, 4'h0);
        applyStimulus(1'b1, 32'h40, 32'h0, 4'h0);
        for (int i = 0; i < 6; i++) begin
            serveTransaction(1, 32'hC0 + 32'(i), seen);
            checkOutput("fair_order", {62'd0, seen}, (i % 2 == 1) ? 64'd2 : 64'd1);
            applyStimulus(modelLastFpu, 32'h50 + 32'(i), 32'(i), 4'h0);
        end
        while (cpu_mem_valid || fpu_mem_valid) serveTransaction(0, 32'h0, seen);

        // FPU write
        applyStimulus(1'b1, 32'h200, 32'h3F800000, 4'hF);
        serveTransaction(2, 32'h0, seen);

        // CPU drops its request mid-transfer: nothing forwarded, fairness unchanged
        applyStimulus(1'b0, 32'h300, 32'h0, 4'h0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("drop_grant", {62'd0, grant_test}, 64'd1);
        cpu_mem_valid = 1'b0;
        mem_ready = 1'b1;
        #1;
        checkOutput("drop_no_fwd", {61'd0, mem_valid, cpu_mem_ready, fpu_mem_ready}, 64'd0);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        checkOutput("drop_idle", {62'd0, grant_test}, 64'd0);
        applyStimulus(1'b0, 32'h310, 32'h0, 4'h0);
        applyStimulus(1'b1, 32'h320, 32'h0, 4'h0);
        serveTransaction(0, 32'h77, seen);
        serveTransaction(0, 32'h78, seen);

        // Reset in the middle of BUSY_FPU, then stray mem_ready in IDLE
        applyStimulus(1'b1, 32'h400, 32'h0, 4'h0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("pre_reset_grant", {62'd0, grant_test}, 64'd2);
        resetn = 1'b0;
        mem_ready = 1'b1;
        #1;
        checkOutput("reset_mid_grant", {62'd0, grant_test}, 64'd0);
        checkOutput("reset_mid_ready", {62'd0, cpu_mem_ready, fpu_mem_ready}, 64'd0);
        @(negedge clk);
        fpu_mem_valid = 1'b0;
        mem_ready = 1'b0;
        resetn = 1'b1;
        modelLastFpu = 1'b1;
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        checkOutput("stray_ready", {61'd0, mem_valid, cpu_mem_ready, fpu_mem_ready}, 64'd0);
        @(negedge clk);
        mem_ready = 1'b0;
        checkOutput("stray_grant", {62'd0, grant_test}, 64'd0);

        // Randomized traffic against the round-robin model
        for (int n = 0; n < 40; n++) begin
            if (!cpu_mem_valid && ($urandom_range(0, 1) == 1))
                applyStimulus(1'b0, $urandom, $urandom, 4'($urandom_range(0, 15)));
            if (!fpu_mem_valid && ($urandom_range(0, 1) == 1))
                applyStimulus(1'b1, $urandom, $urandom, 4'($urandom_range(0, 15)));
            if (!cpu_mem_valid && !fpu_mem_valid)
                applyStimulus(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
            serveTransaction($urandom_range(0, 3), $urandom, seen);
        end
        while (cpu_mem_valid || fpu_mem_valid) serveTransaction(0, 32'h0, seen);

`ifdef MEM_TIMEOUT_EN
        // Memory never answers a CPU read; FPU waits behind it
        applyStimulus(1'b0, 32'h500, 32'h0, 4'h0);
        @(posedge clk);
        applyStimulus(1'b1, 32'h600, 32'h0, 4'h0);
        for (int c = 1; c < 8; c++) begin
            @(negedge clk);
            checkOutput("to_wait", {61'd0, mem_valid, cpu_mem_ready, fpu_mem_ready}, 64'd4);
        end
        @(negedge clk);
        #1;
        checkOutput("to_pulse", {61'd0, mem_valid, cpu_mem_ready, fpu_mem_ready}, 64'd2);
        checkOutput("to_rdata", {32'd0, cpu_mem_rdata}, 64'hDEADBEEF);
        @(negedge clk);
        cpu_mem_valid = 1'b0;
        modelLastFpu = 1'b0;
        checkOutput("to_err", {63'd0, timeout_err}, 64'd1);
        checkOutput("to_idle", {62'd0, grant_test}, 64'd0);
        serveTransaction(0, 32'h99, seen);
        checkOutput("to_fpu_next", {62'd0, seen}, 64'd2);
        checkOutput("timeout_err_final", {63'd0, timeout_err}, 64'd1);
`else
        checkOutput("timeout_err_final", {63'd0, timeout_err}, 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/fpu_mem_arbiter.md
Name: fpu_mem_arbiter

Overview:
Two-master to one-slave arbiter for the native valid/ready memory bus. It merges the CPU core's memory port and the SRFPU coprocessor's memory port (FP load/store traffic) onto a single memory port. It sits directly downstream of the SRFPU memory interface. Arbitration is round-robin with one transaction in flight at a time.

Parameters:
addr_width, 32, address bus width
data_width, 32, data bus width; the strobe width is data_width/8
timeout_cycles, 256, BUSY cycles without mem_ready before abort (used only with the optional feature)

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
cpu_mem_valid  in  1  CPU request
cpu_mem_ready  out  1  CPU transfer-complete pulse
cpu_mem_addr  in  addr_width  CPU address
cpu_mem_wdata  in  data_width  CPU write data
cpu_mem_wstrb  in  data_width/8  CPU byte strobes; 0 means read
cpu_mem_rdata  out  data_width  CPU read data
fpu_mem_valid  in  1  FPU request
fpu_mem_ready  out  1  FPU transfer-complete pulse
fpu_mem_addr  in  addr_width  FPU address
fpu_mem_wdata  in  data_width  FPU write data
fpu_mem_wstrb  in  data_width/8  FPU byte strobes
fpu_mem_rdata  out  data_width  FPU read data
mem_valid  out  1  request to memory
mem_ready  in  1  memory transfer-complete pulse
mem_addr  out  addr_width  memory address
mem_wdata  out  data_width  memory write data
mem_wstrb  out  data_width/8  memory strobes
mem_rdata  in  data_width  memory read data
grant_test  out  2  current state: 00 IDLE, 01 BUSY_CPU, 10 BUSY_FPU
timeout_err  out  1  sticky abort flag; tied to 0 without the optional feature

Behaviour:
- Reset values: state IDLE, last_grant = FPU (so CPU wins the first tie), all outputs 0.
- Master protocol: a master holds valid, addr, wdata and wstrb stable until it sees a one-cycle ready pulse.
- IDLE:
  - mem_valid = 0.
  - Only CPU valid -> BUSY_CPU.
  - Only FPU valid -> BUSY_FPU.
  - Both valid -> grant the master that is not last_grant.
  - The grant is registered, so arbitration adds exactly 1 cycle of latency.
- BUSY_x:
  - mem_valid, mem_addr, mem_wdata and mem_wstrb are combinationally muxed from master x.
  - x_mem_ready = mem_ready; the other master's ready is 0.
- Completion: on mem_ready in BUSY_x:
  - set last_grant = x and go to IDLE;
  - the next grant happens at the earliest on the following cycle (one IDLE cycle between transactions).
- Read data: cpu_mem_rdata and fpu_mem_rdata are both driven by mem_rdata. It is only meaningful alongside the matching ready.
- Master drops valid while in BUSY_x (protocol violation): go to IDLE, leave last_grant unchanged, forward nothing.
- mem_ready while in IDLE (stray or late): ignored and not forwarded.
- Outputs in IDLE: mem_addr, mem_wdata and mem_wstrb are driven to 0.
- Reset asserted mid-transaction: return to IDLE immediately (asynchronous); no ready is issued to any master.
- Fairness: with both masters continuously requesting, grants alternate CPU, FPU, CPU, ...

Optional Feature:
Macro MEM_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle without mem_ready.
  - When the count reaches timeout_cycles-1 with no mem_ready, the arbiter pulses x_mem_ready for one cycle with x_mem_rdata forced to 32'hDEADBEEF (replicated or truncated for other data_width).
  - In that same cycle it sets timeout_err (sticky until reset), deasserts mem_valid, sets last_grant = x and returns to IDLE.
  - mem_ready on the abort cycle takes priority: the transfer completes normally with no error.
- Undefined: no counter; BUSY waits indefinitely and timeout_err = 0.

Test Plan:
- Single CPU read: cpu_mem_valid=1, addr=0x100, wstrb=0; memory returns mem_ready at cycle 3 with rdata=0x12345678 -> grant_test=01 from cycle 1, mem_addr=0x100, cpu_mem_ready pulses once with rdata 0x12345678, fpu_mem_ready stays 0.
- Simultaneous requests after reset: CPU addr=0x10, FPU addr=0x20 both valid -> CPU served first, then one IDLE cycle, then FPU; mem_addr sequence 0x10 then 0x20.
- Continuous contention for 6 transactions, memory ready latency 1 -> grant order CPU, FPU, CPU, FPU, CPU, FPU.
- FPU write: wdata=0x3F800000, wstrb=0xF -> mem_wdata=0x3F800000, mem_wstrb=0xF; cpu_mem_ready never asserted.
- Reset mid BUSY_FPU and stray mem_ready in IDLE -> after reset grant_test=00, no ready pulse to either master; the stray mem_ready is not forwarded.
- MEM_TIMEOUT_EN with timeout_cycles=8 and memory that never responds to a CPU read -> cpu_mem_ready pulses on the 8th BUSY cycle with rdata 0xDEADBEEF, timeout_err=1 and stays 1, a pending FPU request is granted next.
